// File: rtl/band_gain_apply.sv
// band_gain_apply: latches 22 RNN band gains at frame start, interpolates them
// linearly across each band to a per-bin gain and scales every complex bin by it.
// Two pipeline stages: per-bin gain interpolation, then the data multiply/saturate.

// One scaling lane: y = sat32((x * g) >>> 16), full 64-bit signed product.
module bga_scale (
  input  logic signed [31:0] x,
  input  logic signed [31:0] g,
  output logic        [31:0] y
);
  logic signed [63:0] xe, ge, p, sh;

  assign xe = {{32{x[31]}}, x};
  assign ge = {{32{g[31]}}, g};
  assign p  = xe * ge;
  assign sh = p >>> 16;

  // Clamp the Q16.16 result into the 32-bit range.
  always_comb begin
    y = sh[31:0];
    if (sh > 64'sd2147483647)       y = 32'h7FFF_FFFF;
    else if (sh < -64'sd2147483648) y = 32'h8000_0000;
  end
endmodule

module band_gain_apply #(
  parameter int FIXED     = 32,
  parameter int NB_BANDS  = 22,
  parameter int FREQ_SIZE = 481,
  parameter int PIPE      = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NB_BANDS-1:0][FIXED-1:0]     gains,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [FIXED-1:0]                   in_re,
  input  logic [FIXED-1:0]                   in_im,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [FIXED-1:0]                   out_re,
  output logic [FIXED-1:0]                   out_im,
  output logic                               busy,
  output logic                               done
);
  // Reciprocals carry 24 fractional bits so that j*R tracks j/S to well under
  // one output LSB even for band sizes that are not powers of two.
  localparam int RFRAC     = 24;
  localparam int LAST_EDGE = 400;
  localparam int NLANE     = 2;  // re, im

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Band size in bins: 4 * (E[b+1]-E[b]).
  function automatic logic [6:0] band_size(input logic [4:0] bi);
    case (bi)
      5'd0, 5'd1, 5'd2, 5'd3,
      5'd4, 5'd5, 5'd6, 5'd7:  band_size = 7'd4;
      5'd8, 5'd9, 5'd10, 5'd11: band_size = 7'd8;
      5'd12, 5'd13, 5'd14:     band_size = 7'd16;
      5'd15, 5'd16:            band_size = 7'd24;
      5'd17:                   band_size = 7'd32;
      5'd18:                   band_size = 7'd48;
      5'd19:                   band_size = 7'd72;
      default:                 band_size = 7'd88;
    endcase
  endfunction

  // round(2^24 / band_size)
  function automatic logic [22:0] band_recip(input logic [4:0] bi);
    case (bi)
      5'd0, 5'd1, 5'd2, 5'd3,
      5'd4, 5'd5, 5'd6, 5'd7:  band_recip = 23'd4194304;
      5'd8, 5'd9, 5'd10, 5'd11: band_recip = 23'd2097152;
      5'd12, 5'd13, 5'd14:     band_recip = 23'd1048576;
      5'd15, 5'd16:            band_recip = 23'd699051;
      5'd17:                   band_recip = 23'd524288;
      5'd18:                   band_recip = 23'd349525;
      5'd19:                   band_recip = 23'd233017;
      default:                 band_recip = 23'd190650;
    endcase
  endfunction

  state_t                            state;
  logic [NB_BANDS-1:0][FIXED-1:0]    g_lat;
  logic [8:0]                        k, oc;
  logic [4:0]                        b;
  logic [6:0]                        j;
  logic [PIPE:1]                     vld_pipe;
  logic [FIXED-1:0]                  s1_g;
  logic [NLANE-1:0][FIXED-1:0]       s1_d, out_d, lane_y;

  logic                              adv, acc, out_xfer;
  logic [FIXED-1:0]                  gb, gn, g_bin;
  logic [23:0]                       frac;
  logic signed [32:0]                diff;
  logic signed [63:0]                fe, dext, iprod;

  assign adv       = !vld_pipe[PIPE] || out_ready;
  assign in_ready  = (state == RUN) && adv;
  assign acc       = in_valid && in_ready;
  assign out_valid = vld_pipe[PIPE];
  assign out_xfer  = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign out_re    = out_d[0];
  assign out_im    = out_d[1];

  // Stage-1 gain: G[b] + (f * (G[b+1]-G[b])), f = j/S[b]; zero past the last edge.
  // b never exceeds 20 (counters freeze at bin 399), so b+1 stays in range.
  assign gb    = g_lat[b];
  assign gn    = g_lat[b + 5'd1];
  assign frac  = {17'd0, j} * {1'b0, band_recip(b)};
  assign diff  = $signed({gn[FIXED-1], gn}) - $signed({gb[FIXED-1], gb});
  assign fe    = $signed({40'd0, frac});
  assign dext  = {{31{diff[32]}}, diff};
  assign iprod = fe * dext;
  assign g_bin = (k < 9'(LAST_EDGE)) ? gb + 32'(iprod >>> RFRAC) : '0;

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    bga_scale u_scale (.x(s1_d[l]), .g(s1_g), .y(lane_y[l]));
  end

  // Frame FSM, bin/band counters and the stall-all two-stage pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      g_lat    <= '0;
      k        <= '0;
      b        <= '0;
      j        <= '0;
      oc       <= '0;
      vld_pipe <= '0;
      s1_g     <= '0;
      s1_d     <= '0;
      out_d    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (adv) begin
        vld_pipe <= {vld_pipe[PIPE-1:1], acc};
        if (acc) begin
          s1_g <= g_bin;
          s1_d <= {in_im, in_re};
        end
        if (vld_pipe[1]) out_d <= lane_y;
      end
      if (out_xfer) oc <= oc + 9'd1;
      case (state)
        IDLE: if (start) begin
          g_lat <= gains;
          k     <= '0;
          b     <= '0;
          j     <= '0;
          oc    <= '0;
          state <= RUN;
        end
        RUN: if (acc) begin
          k <= k + 9'd1;
          if (k < 9'(LAST_EDGE - 1)) begin
            if (j == band_size(b) - 7'd1) begin
              j <= '0;
              b <= b + 5'd1;
            end else begin
              j <= j + 7'd1;
            end
          end
          if (k == 9'(FREQ_SIZE - 1)) state <= DRAIN;
        end
        DRAIN: if (out_xfer && oc == 9'(FREQ_SIZE - 1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_band_gain_apply.sv
// Directed bench for band_gain_apply: table of expected bins per frame plus
// stall, mid-frame start and mid-frame reset sequences.
module tb_band_gain_apply;
  logic                clk = 1'b0;
  logic                rst_n, start, in_valid, out_ready;
  logic [21:0][31:0]   gains;
  logic [31:0]         in_re, in_im;
  logic                in_ready, out_valid, busy, done;
  logic [31:0]         out_re, out_im;

  band_gain_apply dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gains(gains),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    int          bin;
    logic [31:0] re;
    logic [31:0] im;
  } vec_t;

  vec_t        tbl[$];
  int          total = 0, bad = 0;
  int          cap_n, done_cnt, hold_err, k_acc;
  logic [31:0] cap_re[481], cap_im[481], ref_re[481], ref_im[481];
  logic [21:0][31:0] gv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input logic [31:0] act, input logic [31:0] exp);
    int d;
    d = $signed(act) - $signed(exp);
    total++;
    if (d > 1 || d < -1) begin
      bad++;
      $display("FAIL %s: got %h want %h (+-1)", nm, act, exp);
    end
  endtask

  task automatic check_table(input int f);
    foreach (tbl[i]) if (tbl[i].frame == f) begin
      chk($sformatf("f%0d_bin%0d_re", f, tbl[i].bin), cap_re[tbl[i].bin], tbl[i].re);
      chk($sformatf("f%0d_bin%0d_im", f, tbl[i].bin), cap_im[tbl[i].bin], tbl[i].im);
    end
  endtask

  task automatic run_frame(input logic [21:0][31:0] g, input logic [31:0] re0,
                           input logic [31:0] im0, input logic [31:0] dre,
                           input bit stall, input int abort_at, input bit mid_start);
    int k;
    bit fin, pstall;
    logic [31:0] pre, pim;
    k = 0; fin = 0; pstall = 0; pre = '0; pim = '0;
    cap_n = 0; done_cnt = 0; hold_err = 0;
    @(negedge clk);
    gains = g; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; gains = ~g;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      in_valid  = (k < 481) && (!stall || $urandom_range(0, 1) == 1);
      in_re     = re0 + 32'(k) * dre;
      in_im     = im0 - 32'(k) * dre;
      out_ready = !stall || ($urandom_range(0, 1) == 1);
      start     = mid_start && (k == 100);
      #1;
      if (pstall && (!out_valid || out_re !== pre || out_im !== pim)) hold_err++;
      if (done) begin
        done_cnt++;
        fin = 1;
        chk("busy_low_at_done", busy, 0);
      end
      if (out_valid && out_ready) begin
        if (cap_n < 481) begin
          cap_re[cap_n] = out_re;
          cap_im[cap_n] = out_im;
        end
        cap_n++;
      end
      pstall = out_valid && !out_ready;
      pre = out_re; pim = out_im;
      if (in_valid && in_ready) k++;
      if (abort_at >= 0 && k == abort_at) begin
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_re", out_re, 0);
        chk("abort_out_im", out_im, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk); #1;
          if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    k_acc = k;
    chk("frame_inputs", k, 481);
    chk("frame_outputs", cap_n, 481);
    chk("frame_done_pulses", done_cnt, 1);
    chk("hold_while_stalled", hold_err, 0);
    @(negedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int mis;
    // Frame 1: unity gain passes data through below bin 400, zero above.
    tbl.push_back('{1, 0,   32'h0002_0000, 32'hFFFF_0000});
    tbl.push_back('{1, 1,   32'h0002_0000, 32'hFFFF_0000});
    tbl.push_back('{1, 399, 32'h0002_0000, 32'hFFFF_0000});
    tbl.push_back('{1, 400, 32'h0, 32'h0});
    tbl.push_back('{1, 480, 32'h0, 32'h0});
    // Frame 2: ramp 0 -> 0x1000 across band 0, then back toward 0 in band 1.
    tbl.push_back('{2, 0, 32'h0,    32'h0});
    tbl.push_back('{2, 1, 32'h400,  32'h0});
    tbl.push_back('{2, 2, 32'h800,  32'h0});
    tbl.push_back('{2, 3, 32'hC00,  32'h0});
    tbl.push_back('{2, 4, 32'h1000, 32'h0});
    tbl.push_back('{2, 5, 32'hC00,  32'h0});
    // Frame 3: band 20 endpoints.
    tbl.push_back('{3, 312, 32'h0001_0000, 32'h0});
    tbl.push_back('{3, 400, 32'h0, 32'h0});
    // Frame 4: saturation.
    tbl.push_back('{4, 0,   32'h7FFF_FFFF, 32'h8000_0000});
    tbl.push_back('{4, 399, 32'h7FFF_FFFF, 32'h8000_0000});
    tbl.push_back('{4, 400, 32'h0, 32'h0});

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    gains = '0; in_re = '0; in_im = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) gv[i] = 32'h0001_0000;
    run_frame(gv, 32'h0002_0000, 32'hFFFF_0000, 32'h0, 0, -1, 0);
    check_table(1);

    gv = '0; gv[1] = 32'h0000_1000;
    run_frame(gv, 32'h0001_0000, 32'h0, 32'h0, 0, -1, 0);
    check_table(2);

    gv = '0; gv[20] = 32'h0001_0000;
    run_frame(gv, 32'h0001_0000, 32'h0, 32'h0, 0, -1, 0);
    check_table(3);
    for (int jj = 0; jj < 88; jj++)
      chk_tol($sformatf("band20_j%0d", jj), cap_re[312 + jj],
              32'h0001_0000 - 32'((jj * 65536) / 88));

    for (int i = 0; i < 22; i++) gv[i] = 32'h0002_0000;
    run_frame(gv, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 0, -1, 0);
    check_table(4);

    // Reference frame with varied signed gains and per-bin data.
    for (int i = 0; i < 22; i++) gv[i] = 32'(i * 32'h3000) - 32'h0002_0000;
    run_frame(gv, 32'h0001_0000, 32'hFFFF_0000, 32'h1234, 0, -1, 0);
    for (int i = 0; i < 481; i++) begin
      ref_re[i] = cap_re[i];
      ref_im[i] = cap_im[i];
    end
    chk("ref_bin0_re", ref_re[0], 32'hFFFE_0000);

    // Same frame under random back-pressure, input gaps and a mid-frame start.
    run_frame(gv, 32'h0001_0000, 32'hFFFF_0000, 32'h1234, 1, -1, 1);
    mis = 0;
    for (int i = 0; i < 481; i++)
      if (cap_re[i] !== ref_re[i] || cap_im[i] !== ref_im[i]) mis++;
    chk("stall_sequence_mismatches", mis, 0);

    // Reset mid-frame at bin 200, then a fresh frame must match the reference.
    run_frame(gv, 32'h0001_0000, 32'hFFFF_0000, 32'h1234, 0, 200, 0);
    run_frame(gv, 32'h0001_0000, 32'hFFFF_0000, 32'h1234, 0, -1, 0);
    mis = 0;
    for (int i = 0; i < 481; i++)
      if (cap_re[i] !== ref_re[i] || cap_im[i] !== ref_im[i]) mis++;
    chk("post_reset_sequence_mismatches", mis, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
